// File: rtl/setup_menu_n.sv
// rtl/setup_menu_n.sv - password-guarded configuration menu with shadow copy and atomic commit
// Edits land in a shadow copy; committed registers change only on the edge that enters SAVE.
module setup_menu_n #(
   parameter int N_USERS     = 4,
   parameter int MIN_PW      = 4,
   parameter int MAX_PW      = 12,
   parameter int T_MIN       = 5,
   parameter int T_MAX       = 60,
   parameter int MAX_FAILS   = 3,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   setup_on,
   input  logic [79:0]            digitos_value,
   input  logic                   digitos_valid,
   output logic                   display_en,
   output logic [23:0]            bcd_pac,
   output logic                   bip_status,
   output logic [6:0]             bip_time,
   output logic [6:0]             tranca_aut_time,
   output logic [79:0]            senha_master,
   output logic [N_USERS*80-1:0]  senha_users,
   output logic                   data_setup_ok,
   output logic                   data_setup_abort
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int UW = (N_USERS > 1) ? $clog2(N_USERS) : 1;
   localparam logic [79:0] ALL_E      = {20{4'hE}};
   localparam logic [79:0] ALL_F      = {20{4'hF}};
   localparam logic [79:0] ALL_B      = {20{4'hB}};
   localparam logic [79:0] RST_MASTER = {{16{4'hF}}, 16'h1234};

   typedef enum logic [3:0] {
      S_IDLE, S_AUTH, S_BIP_EN, S_BIP_TIME, S_TRC_TIME, S_MASTER, S_USER, S_SAVE, S_ABORT
   } state_t;

   state_t                state_q, state_d;
   logic [UW-1:0]         user_q, user_d;
   logic [FW-1:0]         fails_q, fails_d;
   logic                  err_q, err_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  sh_bip_status_q, sh_bip_status_d;
   logic [6:0]            sh_bip_time_q, sh_bip_time_d;
   logic [6:0]            sh_trc_time_q, sh_trc_time_d;
   logic [79:0]           sh_master_q, sh_master_d;
   logic [N_USERS*80-1:0] sh_users_q, sh_users_d;
   logic                  cm_bip_status_q;
   logic [6:0]            cm_bip_time_q, cm_trc_time_q;
   logic [79:0]           cm_master_q;
   logic [N_USERS*80-1:0] cm_users_q;
   logic                  commit;

   logic       entry, is_skip, is_save, active;
   logic [3:0] d0, d1, d0_v, d1_v;
   logic       time_bad;
   logic [6:0] time_raw, time_val;
   logic [4:0] pw_len;
   logic       pw_run, pw_gap, pw_ok;
   logic [79:0] pw_val;

   assign entry   = digitos_valid && (digitos_value != ALL_E);
   assign is_skip = (digitos_value == ALL_F);
   assign is_save = (digitos_value == ALL_B);
   assign d0      = digitos_value[3:0];
   assign d1      = digitos_value[7:4];
   assign active  = state_q inside {S_AUTH, S_BIP_EN, S_BIP_TIME, S_TRC_TIME, S_MASTER, S_USER};

   // F digits read as 0; any other non-decimal digit makes the time entry invalid
   always_comb begin
      d0_v     = (d0 == 4'hF) ? 4'd0 : d0;
      d1_v     = (d1 == 4'hF) ? 4'd0 : d1;
      time_bad = (d0 != 4'hF && d0 > 4'd9) || (d1 != 4'hF && d1 > 4'd9);
      time_raw = 7'(d1_v) * 7'd10 + 7'(d0_v);
      if (time_raw < 7'(T_MIN))
         time_val = 7'(T_MIN);
      else if (time_raw > 7'(T_MAX))
         time_val = 7'(T_MAX);
      else
         time_val = time_raw;
   end

   // Password length is the run of non-F digits from digit[0]; a later non-F is a gap
   always_comb begin
      pw_len = 5'd0;
      pw_run = 1'b1;
      pw_gap = 1'b0;
      pw_val = ALL_F;
      for (int i = 0; i < 20; i++) begin
         if (digitos_value[4*i +: 4] == 4'hF) begin
            pw_run = 1'b0;
         end else if (pw_run) begin
            pw_len = pw_len + 5'd1;
            if (i < MAX_PW)
               pw_val[4*i +: 4] = digitos_value[4*i +: 4];
         end else begin
            pw_gap = 1'b1;
         end
      end
      pw_ok = !pw_gap && (pw_len >= 5'(MIN_PW)) && (pw_len <= 5'(MAX_PW));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         user_q          <= '0;
         fails_q         <= '0;
         err_q           <= 1'b0;
         timer_q         <= '0;
         sh_bip_status_q <= 1'b1;
         sh_bip_time_q   <= 7'd5;
         sh_trc_time_q   <= 7'd5;
         sh_master_q     <= RST_MASTER;
         sh_users_q      <= '1;
         cm_bip_status_q <= 1'b1;
         cm_bip_time_q   <= 7'd5;
         cm_trc_time_q   <= 7'd5;
         cm_master_q     <= RST_MASTER;
         cm_users_q      <= '1;
      end else begin
         state_q         <= state_d;
         user_q          <= user_d;
         fails_q         <= fails_d;
         err_q           <= err_d;
         timer_q         <= timer_d;
         sh_bip_status_q <= sh_bip_status_d;
         sh_bip_time_q   <= sh_bip_time_d;
         sh_trc_time_q   <= sh_trc_time_d;
         sh_master_q     <= sh_master_d;
         sh_users_q      <= sh_users_d;
         if (commit) begin
            cm_bip_status_q <= sh_bip_status_d;
            cm_bip_time_q   <= sh_bip_time_d;
            cm_trc_time_q   <= sh_trc_time_d;
            cm_master_q     <= sh_master_d;
            cm_users_q      <= sh_users_d;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      user_d          = user_q;
      fails_d         = fails_q;
      err_d           = err_q;
      sh_bip_status_d = sh_bip_status_q;
      sh_bip_time_d   = sh_bip_time_q;
      sh_trc_time_d   = sh_trc_time_q;
      sh_master_d     = sh_master_q;
      sh_users_d      = sh_users_q;

      if (state_q == S_IDLE || digitos_valid)
         timer_d = '0;
      else
         timer_d = timer_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (setup_on) begin
               state_d         = S_AUTH;
               user_d          = '0;
               fails_d         = '0;
               err_d           = 1'b0;
               sh_bip_status_d = cm_bip_status_q;
               sh_bip_time_d   = cm_bip_time_q;
               sh_trc_time_d   = cm_trc_time_q;
               sh_master_d     = cm_master_q;
               sh_users_d      = cm_users_q;
            end
         end
         S_SAVE, S_ABORT: state_d = S_IDLE;
         default: ;
      endcase

      if (active) begin
         if (!setup_on) begin
            state_d = S_ABORT;
         end else if (entry) begin
            if (state_q == S_AUTH) begin
               if (is_save) begin
                  state_d = S_ABORT;
               end else if (digitos_value == cm_master_q) begin
                  state_d = S_BIP_EN;
                  err_d   = 1'b0;
               end else begin
                  err_d   = 1'b1;
                  fails_d = fails_q + FW'(1);
                  if (fails_q == FW'(MAX_FAILS - 1))
                     state_d = S_ABORT;
               end
            end else if (is_save) begin
               state_d = S_SAVE;
            end else begin
               err_d = 1'b0;
               case (state_q)
                  S_BIP_EN: begin
                     if (!is_skip && d0 > 4'd1)
                        err_d = 1'b1;
                     else begin
                        if (!is_skip) sh_bip_status_d = d0[0];
                        state_d = S_BIP_TIME;
                     end
                  end
                  S_BIP_TIME: begin
                     if (!is_skip && time_bad)
                        err_d = 1'b1;
                     else begin
                        if (!is_skip) sh_bip_time_d = time_val;
                        state_d = S_TRC_TIME;
                     end
                  end
                  S_TRC_TIME: begin
                     if (!is_skip && time_bad)
                        err_d = 1'b1;
                     else begin
                        if (!is_skip) sh_trc_time_d = time_val;
                        state_d = S_MASTER;
                     end
                  end
                  S_MASTER: begin
                     if (!is_skip && !pw_ok)
                        err_d = 1'b1;
                     else begin
                        if (!is_skip) sh_master_d = pw_val;
                        state_d = S_USER;
                        user_d  = '0;
                     end
                  end
                  S_USER: begin
                     if (!is_skip && !pw_ok)
                        err_d = 1'b1;
                     else begin
                        if (!is_skip) sh_users_d[int'(user_q)*80 +: 80] = pw_val;
                        if (user_q == UW'(N_USERS - 1))
                           state_d = S_SAVE;
                        else
                           user_d = user_q + UW'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end else if (!digitos_valid && timer_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_ABORT;
         end
      end

      commit = (state_d == S_SAVE) && (state_q != S_SAVE);
   end

   always_comb begin
      bcd_pac          = '1;
      display_en       = (state_q != S_IDLE);
      data_setup_ok    = (state_q == S_SAVE);
      data_setup_abort = (state_q == S_ABORT);
      if (state_q != S_IDLE)
         bcd_pac[19:16] = err_q ? 4'hE : 4'hF;
      case (state_q)
         S_AUTH:     bcd_pac[23:20] = 4'hA;
         S_BIP_EN: begin
            bcd_pac[23:20] = 4'h1;
            bcd_pac[3:0]   = {3'b000, sh_bip_status_q};
         end
         S_BIP_TIME: begin
            bcd_pac[23:20] = 4'h2;
            bcd_pac[7:0]   = {4'(sh_bip_time_q / 7'd10), 4'(sh_bip_time_q % 7'd10)};
         end
         S_TRC_TIME: begin
            bcd_pac[23:20] = 4'h3;
            bcd_pac[7:0]   = {4'(sh_trc_time_q / 7'd10), 4'(sh_trc_time_q % 7'd10)};
         end
         S_MASTER:   bcd_pac[23:20] = 4'h4;
         S_USER:     bcd_pac[23:20] = 4'd5 + 4'(user_q);
         default: ;
      endcase
   end

   assign bip_status      = cm_bip_status_q;
   assign bip_time        = cm_bip_time_q;
   assign tranca_aut_time = cm_trc_time_q;
   assign senha_master    = cm_master_q;
   assign senha_users     = cm_users_q;

endmodule

// File: tb/tb_setup_menu_n.sv
// tb/tb_setup_menu_n.sv - directed self-checking bench for setup_menu_n
// Inputs change on the falling edge; outputs are sampled on the falling edge after the applying rise.
module tb_setup_menu_n;
   localparam logic [79:0] ALL_E      = {20{4'hE}};
   localparam logic [79:0] ALL_F      = {20{4'hF}};
   localparam logic [79:0] ALL_B      = {20{4'hB}};
   localparam logic [79:0] RST_MASTER = {{16{4'hF}}, 16'h1234};

   logic         clk = 1'b0;
   logic         rst, setup_on, digitos_valid;
   logic [79:0]  digitos_value;
   logic         display_en, bip_status, data_setup_ok, data_setup_abort;
   logic [23:0]  bcd_pac;
   logic [6:0]   bip_time, tranca_aut_time;
   logic [79:0]  senha_master;
   logic [319:0] senha_users;
   int tests = 0;
   int fails = 0;

   setup_menu_n #(.TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst), .setup_on(setup_on),
      .digitos_value(digitos_value), .digitos_valid(digitos_valid),
      .display_en(display_en), .bcd_pac(bcd_pac),
      .bip_status(bip_status), .bip_time(bip_time), .tranca_aut_time(tranca_aut_time),
      .senha_master(senha_master), .senha_users(senha_users),
      .data_setup_ok(data_setup_ok), .data_setup_abort(data_setup_abort)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] pk(input logic [79:0] low, input int n);
      logic [79:0] r;
      r = ALL_F;
      for (int i = 0; i < n; i++) r[4*i +: 4] = low[4*i +: 4];
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; setup_on = 1'b0; digitos_valid = 1'b0; digitos_value = ALL_E;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_session();
      setup_on = 1'b1;
      @(negedge clk);
   endtask

   task automatic entry(input logic [79:0] v);
      digitos_value = v; digitos_valid = 1'b1;
      @(negedge clk);
      digitos_valid = 1'b0; digitos_value = ALL_E;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (display_en !== 1'b0) begin fails++; $display("FAIL reset_display_en: got %b want 0", display_en); end
      tests++; if (bcd_pac !== 24'hFFFFFF) begin fails++; $display("FAIL reset_bcd: got %h want FFFFFF", bcd_pac); end
      tests++; if (bip_status !== 1'b1 || bip_time !== 7'd5 || tranca_aut_time !== 7'd5) begin
         fails++; $display("FAIL reset_times: got %b/%0d/%0d want 1/5/5", bip_status, bip_time, tranca_aut_time); end
      tests++; if (senha_master !== RST_MASTER) begin fails++; $display("FAIL reset_master: got %h want %h", senha_master, RST_MASTER); end
      tests++; if (senha_users !== {320{1'b1}}) begin fails++; $display("FAIL reset_users: got %h want all F", senha_users); end
      tests++; if (data_setup_ok !== 1'b0 || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL reset_pulses: got ok=%b abort=%b want 0/0", data_setup_ok, data_setup_abort); end
   endtask

   task automatic test_happy();
      start_session();
      tests++; if (bcd_pac[23:20] !== 4'hA || display_en !== 1'b1) begin
         fails++; $display("FAIL happy_auth: got code %h en %b want A 1", bcd_pac[23:20], display_en); end
      entry(pk(80'h1234, 4));
      tests++; if (bcd_pac !== 24'h1FFFF1) begin fails++; $display("FAIL happy_bip_en: got %h want 1FFFF1", bcd_pac); end
      entry(pk(80'h0, 1));
      tests++; if (bcd_pac !== 24'h2FFF05) begin fails++; $display("FAIL happy_bip_time: got %h want 2FFF05", bcd_pac); end
      entry(pk(80'h45, 2));
      tests++; if (bcd_pac !== 24'h3FFF05) begin fails++; $display("FAIL happy_trc_time: got %h want 3FFF05", bcd_pac); end
      entry(pk(80'h07, 2));
      tests++; if (bcd_pac !== 24'h4FFFFF) begin fails++; $display("FAIL happy_master: got %h want 4FFFFF", bcd_pac); end
      entry(pk(80'h98765, 5));
      tests++; if (bcd_pac !== 24'h5FFFFF) begin fails++; $display("FAIL happy_user0: got %h want 5FFFFF", bcd_pac); end
      entry(pk(80'h2468, 4));
      tests++; if (bcd_pac[23:20] !== 4'h6) begin fails++; $display("FAIL happy_user1: got %h want 6", bcd_pac[23:20]); end
      entry(ALL_B);
      tests++; if (data_setup_ok !== 1'b1 || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL happy_ok_pulse: got ok=%b abort=%b want 1/0", data_setup_ok, data_setup_abort); end
      tests++; if (bip_status !== 1'b0 || bip_time !== 7'd45 || tranca_aut_time !== 7'd7) begin
         fails++; $display("FAIL happy_times: got %b/%0d/%0d want 0/45/7", bip_status, bip_time, tranca_aut_time); end
      tests++; if (senha_master !== pk(80'h98765, 5)) begin fails++; $display("FAIL happy_master_val: got %h", senha_master); end
      tests++; if (senha_users[79:0] !== pk(80'h2468, 4) || senha_users[319:80] !== {240{1'b1}}) begin
         fails++; $display("FAIL happy_users: got %h", senha_users); end
      setup_on = 1'b0;
      @(negedge clk);
      tests++; if (data_setup_ok !== 1'b0 || display_en !== 1'b0) begin
         fails++; $display("FAIL happy_ok_width: got ok=%b en=%b want 0/0", data_setup_ok, display_en); end
   endtask

   task automatic test_clamp();
      start_session();
      entry(pk(80'h98765, 5));
      tests++; if (bcd_pac !== 24'h1FFFF0) begin fails++; $display("FAIL clamp_shadow_bip: got %h want 1FFFF0", bcd_pac); end
      entry(ALL_F);
      tests++; if (bcd_pac !== 24'h2FFF45) begin fails++; $display("FAIL clamp_shadow_time: got %h want 2FFF45", bcd_pac); end
      entry(pk(80'h1A, 2));
      tests++; if (bcd_pac !== 24'h2EFF45) begin fails++; $display("FAIL clamp_reject_1A: got %h want 2EFF45", bcd_pac); end
      entry(pk(80'h02, 2));
      tests++; if (bcd_pac !== 24'h3FFF07) begin fails++; $display("FAIL clamp_accept_02: got %h want 3FFF07", bcd_pac); end
      entry(pk(80'h99, 2));
      tests++; if (bcd_pac[23:20] !== 4'h4) begin fails++; $display("FAIL clamp_advance_99: got %h want 4", bcd_pac[23:20]); end
      entry(ALL_B);
      tests++; if (data_setup_ok !== 1'b1 || bip_time !== 7'd5 || tranca_aut_time !== 7'd60 || bip_status !== 1'b0) begin
         fails++; $display("FAIL clamp_commit: got ok=%b %0d/%0d/%b want 1 5/60/0", data_setup_ok, bip_time, tranca_aut_time, bip_status); end
      setup_on = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      start_session();
      entry(pk(80'h98765, 5));
      entry(pk(80'h1, 1));
      entry(ALL_F);
      entry(ALL_F);
      entry(pk(80'h5555, 4));
      entry(pk(80'h1111, 4));
      tests++; if (bcd_pac[23:20] !== 4'h6) begin fails++; $display("FAIL mid_user1: got %h want 6", bcd_pac[23:20]); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (display_en !== 1'b0 || bcd_pac !== 24'hFFFFFF) begin
         fails++; $display("FAIL mid_idle: got en=%b bcd=%h want 0 FFFFFF", display_en, bcd_pac); end
      tests++; if (bip_status !== 1'b1 || bip_time !== 7'd5 || tranca_aut_time !== 7'd5 || senha_master !== RST_MASTER) begin
         fails++; $display("FAIL mid_committed: got %b/%0d/%0d/%h", bip_status, bip_time, tranca_aut_time, senha_master); end
      tests++; if (senha_users !== {320{1'b1}}) begin fails++; $display("FAIL mid_users: got %h", senha_users); end
      @(negedge clk);
      rst = 1'b0; setup_on = 1'b0;
      @(negedge clk);
      tests++; if (data_setup_ok !== 1'b0 || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL mid_no_pulse: got ok=%b abort=%b want 0/0", data_setup_ok, data_setup_abort); end
   endtask

   task automatic test_auth_fail();
      logic [79:0] wrong [3];
      wrong[0] = pk(80'h1111, 4); wrong[1] = pk(80'h123, 3); wrong[2] = pk(80'h12345, 5);
      do_reset();
      start_session();
      for (int i = 0; i < 2; i++) begin
         entry(wrong[i]);
         tests++; if (bcd_pac !== 24'hAEFFFF || data_setup_abort !== 1'b0) begin
            fails++; $display("FAIL auth_err_%0d: got %h abort=%b want AEFFFF 0", i, bcd_pac, data_setup_abort); end
      end
      entry(wrong[2]);
      tests++; if (data_setup_abort !== 1'b1 || data_setup_ok !== 1'b0 || bcd_pac !== 24'hFEFFFF) begin
         fails++; $display("FAIL auth_abort: got abort=%b ok=%b bcd=%h want 1 0 FEFFFF", data_setup_abort, data_setup_ok, bcd_pac); end
      tests++; if (senha_master !== RST_MASTER || bip_time !== 7'd5 || bip_status !== 1'b1) begin
         fails++; $display("FAIL auth_unchanged: got %h/%0d/%b", senha_master, bip_time, bip_status); end
      setup_on = 1'b0;
      @(negedge clk);
      tests++; if (data_setup_abort !== 1'b0) begin fails++; $display("FAIL auth_abort_width: got %b want 0", data_setup_abort); end
   endtask

   task automatic test_pw_len();
      do_reset();
      start_session();
      entry(pk(80'h1234, 4));
      repeat (3) entry(ALL_F);
      tests++; if (bcd_pac !== 24'h4FFFFF) begin fails++; $display("FAIL pw_master_state: got %h want 4FFFFF", bcd_pac); end
      entry(pk(80'h123, 3));
      tests++; if (bcd_pac !== 24'h4EFFFF) begin fails++; $display("FAIL pw_short: got %h want 4EFFFF", bcd_pac); end
      entry(pk(80'h1234567890123, 13));
      tests++; if (bcd_pac !== 24'h4EFFFF) begin fails++; $display("FAIL pw_long: got %h want 4EFFFF", bcd_pac); end
      entry(pk(80'h1F234, 5));
      tests++; if (bcd_pac !== 24'h4EFFFF) begin fails++; $display("FAIL pw_gap: got %h want 4EFFFF", bcd_pac); end
      entry(pk(80'h1234, 4));
      tests++; if (bcd_pac !== 24'h5FFFFF) begin fails++; $display("FAIL pw_accept: got %h want 5FFFFF", bcd_pac); end
      for (int u = 0; u < 4; u++) begin
         entry(ALL_F);
         if (u < 3) begin
            tests++; if (bcd_pac[23:20] !== 4'(6 + u)) begin
               fails++; $display("FAIL pw_skip_user%0d: got %h want %h", u, bcd_pac[23:20], 4'(6 + u)); end
         end
      end
      tests++; if (data_setup_ok !== 1'b1 || senha_users !== {320{1'b1}} || senha_master !== pk(80'h1234, 4)) begin
         fails++; $display("FAIL pw_save: got ok=%b master=%h users=%h", data_setup_ok, senha_master, senha_users); end
      setup_on = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout_exit();
      do_reset();
      start_session();
      entry(pk(80'h1234, 4));
      entry(pk(80'h0, 1));
      entry(pk(80'h30, 2));
      repeat (99) @(negedge clk);
      tests++; if (bcd_pac[23:20] !== 4'h3 || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL to_early: got %h abort=%b want 3 0", bcd_pac[23:20], data_setup_abort); end
      @(negedge clk);
      tests++; if (data_setup_abort !== 1'b1) begin fails++; $display("FAIL to_abort: got %b want 1", data_setup_abort); end
      tests++; if (bip_status !== 1'b1 || bip_time !== 7'd5) begin
         fails++; $display("FAIL to_discard: got %b/%0d want 1/5", bip_status, bip_time); end
      repeat (2) @(negedge clk);
      tests++; if (bcd_pac[23:20] !== 4'hA) begin fails++; $display("FAIL to_restart: got %h want A", bcd_pac[23:20]); end
      repeat (99) @(negedge clk);
      digitos_valid = 1'b1; digitos_value = ALL_E;
      @(negedge clk);
      digitos_valid = 1'b0;
      tests++; if (bcd_pac[23:20] !== 4'hA || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL to_valid_wins: got %h abort=%b want A 0", bcd_pac[23:20], data_setup_abort); end
      entry(pk(80'h1234, 4));
      repeat (3) entry(ALL_F);
      setup_on = 1'b0;
      @(negedge clk);
      tests++; if (data_setup_abort !== 1'b1) begin fails++; $display("FAIL exit_abort: got %b want 1", data_setup_abort); end
      @(negedge clk);
      tests++; if (display_en !== 1'b0 || data_setup_abort !== 1'b0) begin
         fails++; $display("FAIL exit_idle: got en=%b abort=%b want 0 0", display_en, data_setup_abort); end
   endtask

   initial begin
      test_reset();
      test_happy();
      test_clamp();
      test_reset_mid();
      test_auth_fail();
      test_pw_len();
      test_timeout_exit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
